// File: rtl/repeat_byte_stream.sv
// repeat_byte_stream
//   Accepts one WIDTH-bit base value x and emits COUNT derived beats
//   x + k*STEP (k = 1..COUNT, mod 2^WIDTH), ascending or descending.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready base value handshake; in_data = x, in_descending = order
//   out_valid/out_ready beat handshake; out_data, out_last, out_index describe
//                     the current beat
//   dbg_state_o       current FSM state (0 = IDLE, 1 = EMIT) for checkers
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until the transfer; ready may depend combinationally on the other
// side (in_ready depends on out_ready so a new base can be taken on the
// cycle the last beat leaves, giving back-to-back sequences with no bubble).
module repeat_byte_stream #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int STEP  = 1,
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_descending,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [IDX_W-1:0] out_index,
  output logic             dbg_state_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Both constants are truncated to WIDTH, so all arithmetic wraps silently.
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] TOTAL_W = WIDTH'(COUNT * STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             desc_q, desc_d;
  logic             accept;

  assign out_valid   = (state_q == EMIT);
  assign out_data    = data_q;
  assign out_last    = last_q;
  assign out_index   = idx_q;
  assign dbg_state_o = state_q;

  assign in_ready = rst_n & ((state_q == IDLE) | (out_valid & out_ready & last_q));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    desc_d  = desc_q;
    if (accept) begin
      // First beat of a new sequence, whether from IDLE or straight after a
      // completing last beat.
      state_d = EMIT;
      desc_d  = in_descending;
      data_d  = in_descending ? (in_data + TOTAL_W) : (in_data + STEP_W);
      idx_d   = '0;
      last_d  = (COUNT == 1);
    end else if ((state_q == EMIT) && out_ready) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        data_d = desc_q ? (data_q - STEP_W) : (data_q + STEP_W);
        idx_d  = idx_q + IDX_W'(1);
        // The beat being advanced to is the last one when its index is COUNT-1.
        last_d = ((int'(idx_q) + 2) == COUNT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      desc_q  <= desc_d;
    end
  end

endmodule
